// File: rtl/booth_r4_seq_multiplier.sv
// booth_r4_seq_multiplier: radix-4 Booth sequential multiplier.
// Retires two multiplier bits per clock and returns the full 2*WIDTH-bit product.
// It supports signed and unsigned operation, selected per transaction.
// Optional feature macro: MUL_ZERO_BYPASS_EN. When it is defined, a zero operand
// skips the CALC state and the block returns a product of 0 one cycle after accept.
//
// Handshake semantics (valid/ready):
// - Input side: a transfer happens on a rising edge where in_valid && in_ready.
//   in_ready is high only in IDLE, so in_valid at any other time is ignored.
//   Operands are captured on that edge. Later changes to the inputs have no effect.
// - Output side: out_valid is high only in DONE, and product is held stable
//   there. A transfer happens on an edge where out_valid && out_ready, and the
//   block then returns to IDLE. Backpressure may last without limit.
//   out_ready is ignored while out_valid is low.
module booth_r4_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int CW   = $clog2(ITER + 1);

  generate
    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("booth_r4_seq_multiplier: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nx;
  logic [WIDTH+1:0]   a_ext;     // extended multiplicand
  logic [WIDTH+1:0]   mreg;      // multiplier bits, low half of the shift register
  logic               prev;      // B[2i-1]; holds 0 for the first triplet
  logic [WIDTH+3:0]   acc;       // upper accumulator half, two guard bits for +-2A
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod_r;

  logic [WIDTH+3:0]   a4, a2, digit, sum, acc_nx;
  logic [WIDTH+1:0]   mreg_nx;
  logic [2*WIDTH-1:0] prod_nx;
  logic               last_iter;

`ifdef MUL_ZERO_BYPASS_EN
  logic zero_in;
  assign zero_in = (multiplicand == '0) || (multiplier == '0);
`endif

  // Sign extension or zero extension gives one datapath for both modes
  function automatic logic [WIDTH+1:0] extend(input logic [WIDTH-1:0] x, input logic s);
    return s ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
  endfunction

  assign last_iter = (cnt == CW'(ITER - 1));

  // Booth digit selection, accumulation and a 2-bit arithmetic shift of {acc, mreg}
  always_comb begin
    a4 = {{2{a_ext[WIDTH+1]}}, a_ext};
    a2 = {a4[WIDTH+2:0], 1'b0};
    digit = '0;
    case ({mreg[1:0], prev})
      3'b001, 3'b010: digit = a4;
      3'b011:         digit = a2;
      3'b100:         digit = ~a2 + 1'b1;
      3'b101, 3'b110: digit = ~a4 + 1'b1;
      default:        digit = '0;
    endcase
    sum     = acc + digit;
    acc_nx  = {{2{sum[WIDTH+3]}}, sum[WIDTH+3:2]};
    mreg_nx = {sum[1:0], mreg[WIDTH+1:2]};
    prod_nx = {acc_nx[WIDTH-3:0], mreg_nx};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef MUL_ZERO_BYPASS_EN
          state_nx = zero_in ? DONE : CALC;
`else
          state_nx = CALC;
`endif
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last_iter) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, iteration, and latching of the final product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_ext  <= '0;
      mreg   <= '0;
      prev   <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      prod_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_ext <= extend(multiplicand, signed_op);
            mreg  <= extend(multiplier, signed_op);
            prev  <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
`ifdef MUL_ZERO_BYPASS_EN
            if (zero_in) prod_r <= '0;
`endif
          end
        end
        CALC: begin
          acc  <= acc_nx;
          mreg <= mreg_nx;
          prev <= mreg[1];
          cnt  <= cnt + CW'(1);
          if (last_iter) prod_r <= prod_nx;
        end
        default: ;
      endcase
    end
  end

  assign product = prod_r;

endmodule
